// File: rtl/dmem_rw.sv
// ---------------------------------------------------------------------------
// dmem_rw : data memory for the single-cycle CPU.
//
// A word-organised RAM of DEPTH 32-bit words with:
//   - byte / half / word stores that merge into the existing word by lane;
//   - combinational sub-word loads, sign- or zero-extended;
//   - a clear engine that zeroes the whole array after reset, one word per
//     cycle, while busy is high.
//
// Optional feature (macro DMEM_ERR_EN):
//   When DMEM_ERR_EN is defined, misaligned and out-of-range accesses raise
//   err, suppress the store and force data_read to zero.
//   When it is undefined, err is tied low, the low address bits that a half
//   or word access does not need are ignored, and addresses wrap modulo
//   DEPTH*4.
//
// Ports:
//   clk        in   1       rising-edge clock
//   reset_n    in   1       synchronous active-low reset
//   we         in   1       store strobe
//   size       in   2       00 byte, 01 half, 10/11 word
//   sign_ext   in   1       1 = sign-extend sub-word loads
//   addr       in   ADDR_W  byte address
//   data_write in   32      store data, low-aligned
//   data_read  out  32      load data (combinational)
//   busy       out  1       clear engine active
//   err        out  1       access error (combinational)
// ---------------------------------------------------------------------------
module dmem_rw #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_write,
    output logic [31:0]       data_read,
    output logic              busy,
    output logic              err
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  clr_ptr_q;
    logic [IDX_W-1:0]  clr_ptr_d;
    logic [31:0]       mem_q [DEPTH];

    logic [IDX_W-1:0]  idx_s;
    logic              busy_s;
    logic              err_s;
    logic              st_en_s;
    logic [3:0]        wr_be_s;
    logic [31:0]       wr_data_s;
    logic [31:0]       word_s;
    logic [31:0]       byte_sh_s;
    logic [31:0]       half_sh_s;
    logic [31:0]       load_s;
    logic              unused_addr_s;

    assign idx_s  = addr[IDX_W+1:2];
    assign busy_s = (state_q == ST_CLEAR);

    // Upper address bits only matter for the range check; keep lint quiet
    // in the build that ignores them.
    assign unused_addr_s = ^addr;

    // Access error detection: misalignment and out-of-range, never while busy.
    always_comb begin
        err_s = 1'b0;
`ifdef DMEM_ERR_EN
        if (busy_s) begin
            err_s = 1'b0;
        end else if ((size == 2'b01) && addr[0]) begin
            err_s = 1'b1;
        end else if (size[1] && (addr[1:0] != 2'b00)) begin
            err_s = 1'b1;
        end else if ((addr >> (IDX_W + 2)) != '0) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
`else
        err_s = 1'b0;
`endif
    end

    // Clear FSM next-state: walk clr_ptr across the array, then park in IDLE.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + {{(IDX_W-1){1'b0}}, 1'b1};
                if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Clear FSM state register; reset restarts the clear from word 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Store lane enables and lane-replicated store data.
    always_comb begin
        wr_be_s   = 4'b0000;
        wr_data_s = data_write;
        case (size)
            2'b00: begin
                wr_be_s   = 4'b0001 << addr[1:0];
                wr_data_s = {4{data_write[7:0]}};
            end
            2'b01: begin
                wr_be_s   = addr[1] ? 4'b1100 : 4'b0011;
                wr_data_s = {2{data_write[15:0]}};
            end
            default: begin
                wr_be_s   = 4'b1111;
                wr_data_s = data_write;
            end
        endcase
    end

    assign st_en_s = (state_q == ST_IDLE) && we && !err_s;

    // Memory array: clear-engine zeroing or lane-merged stores.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_ptr_q] <= 32'h0000_0000;
            end else if (st_en_s) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be_s[b]) begin
                        mem_q[idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
                    end
                end
            end
        end
    end

    // Combinational load: lane select plus sign/zero extension.
    always_comb begin
        word_s    = mem_q[idx_s];
        byte_sh_s = word_s >> {addr[1:0], 3'b000};
        half_sh_s = word_s >> {addr[1], 4'b0000};
        case (size)
            2'b00:   load_s = {{24{sign_ext & byte_sh_s[7]}}, byte_sh_s[7:0]};
            2'b01:   load_s = {{16{sign_ext & half_sh_s[15]}}, half_sh_s[15:0]};
            default: load_s = word_s;
        endcase
        if (busy_s || err_s) begin
            data_read = 32'h0000_0000;
        end else begin
            data_read = load_s;
        end
    end

    assign busy = busy_s;
    assign err  = err_s;

endmodule

// File: tb/tb_dmem_rw.sv
// ---------------------------------------------------------------------------
// tb_dmem_rw : self-checking bench for dmem_rw (DEPTH=256, ADDR_W=32).
// A word-array reference model computes expected loads, stores and errors
// from the addressing rules using plain arithmetic.
// ---------------------------------------------------------------------------
module tb_dmem_rw;

    localparam int DEPTH = 256;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        busy;
    logic        err;

    int          total;
    int          bad;
    logic [31:0] model_mem [DEPTH];

    dmem_rw #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .we         (we),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .data_write (data_write),
        .data_read  (data_read),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
`ifdef DMEM_ERR_EN
        if (sz == 2'b01 && a[0]) return 1'b1;
        if (sz[1] && (a % 4) != 0) return 1'b1;
        if (a >= DEPTH * 4) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic sx);
        logic [31:0] w;
        logic [31:0] v;
        if (model_err(a, sz)) return 32'h0;
        w = model_mem[(a / 4) % DEPTH];
        if (sz == 2'b00) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int          idx;
        int          sh;
        logic [31:0] mask;
        if (model_err(a, sz)) return;
        idx = (a / 4) % DEPTH;
        if (sz == 2'b00) begin
            sh   = 8 * (a % 4);
            mask = 32'hFF << sh;
            model_mem[idx] = (model_mem[idx] & ~mask) | ((d & 32'hFF) << sh);
        end else if (sz == 2'b01) begin
            sh   = 16 * ((a / 2) % 2);
            mask = 32'hFFFF << sh;
            model_mem[idx] = (model_mem[idx] & ~mask) | ((d & 32'hFFFF) << sh);
        end else begin
            model_mem[idx] = d;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    // One access: check the pre-edge load/err against the model, then clock it.
    task automatic do_op(input string tag, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] d);
        we = w; size = sz; sign_ext = sx; addr = a; data_write = d;
        #1;
        check({tag, "_rd"}, data_read, model_load(a, sz, sx));
        check({tag, "_err"}, {31'h0, err}, {31'h0, model_err(a, sz)});
        tick();
        if (w) model_store(a, sz, d);
        we = 1'b0;
    endtask

    // Directed load compared against a hand-computed constant.
    task automatic load_const(input string tag, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] exp);
        we = 1'b0; size = sz; sign_ext = sx; addr = a;
        #1;
        check(tag, data_read, exp);
    endtask

    // Count edges until busy drops; bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; we = 1'b0; size = 2'b10; sign_ext = 1'b0;
        addr = 32'h0; data_write = 32'h0;
        model_clear();

        // 1. Clear timing, store ignored while busy.
        tick(); tick(); tick();
        check("busy_in_reset", {31'h0, busy}, 32'h1);
        reset_n = 1'b1;
        we = 1'b1; size = 2'b10; addr = 32'h0; data_write = 32'hDEAD_BEEF;
        #1;
        check("rd_during_clear", data_read, 32'h0);
        check("err_during_clear", {31'h0, err}, 32'h0);
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
            if (!busy) we = 1'b0;
        end
        we = 1'b0;
        check("clear_cycles", n, 32'd256);
        load_const("clr_3fc", 2'b10, 1'b0, 32'h3FC, 32'h0);
        load_const("busy_store_ignored", 2'b10, 1'b0, 32'h0, 32'h0);

        // 2. Byte store into a word, signed/unsigned byte loads.
        do_op("t2w", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
        do_op("t2b", 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AB);
        load_const("t2_word", 2'b10, 1'b0, 32'h10, 32'h11AB_3344);
        load_const("t2_lb_s", 2'b00, 1'b1, 32'h12, 32'hFFFF_FFAB);
        load_const("t2_lb_u", 2'b00, 1'b0, 32'h12, 32'h0000_00AB);

        // 3. Half store into a zeroed word.
        do_op("t3h", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001);
        load_const("t3_word", 2'b10, 1'b0, 32'h20, 32'h8001_0000);
        load_const("t3_lh_s", 2'b01, 1'b1, 32'h22, 32'hFFFF_8001);
        load_const("t3_lh_u", 2'b01, 1'b0, 32'h22, 32'h0000_8001);

        // 5. Read-during-write: old value before the edge, new after.
        do_op("t5a", 1'b1, 2'b10, 1'b0, 32'h40, 32'h5);
        we = 1'b1; size = 2'b10; addr = 32'h40; data_write = 32'h7;
        #1;
        check("rdw_before", data_read, 32'h5);
        tick();
        model_store(32'h40, 2'b10, 32'h7);
        we = 1'b0;
        #1;
        check("rdw_after", data_read, 32'h7);

        // 6. Misaligned and out-of-range stores (model covers both builds).
        do_op("t6_mis", 1'b1, 2'b10, 1'b0, 32'h42, 32'hCAFE_0001);
        do_op("t6_mis_rd", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        do_op("t6_oor", 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFE_0002);
        do_op("t6_oor_rd", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        do_op("t6_hmis", 1'b1, 2'b01, 1'b0, 32'h51, 32'h0000_BEEF);
        do_op("t6_hmis_rd", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0);

        // Randomized mix of stores and loads against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) != 0) a = $urandom_range(0, DEPTH * 4 - 1);
            else a = $urandom;
            do_op("rnd", ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), a, $urandom);
        end

        // 4. Reset mid-clear restarts the full clear.
        for (int i = 0; i < 8; i++) do_op("pre4", 1'b1, 2'b10, 1'b0, 32'(i * 4), 32'hA5A5_0000 + 32'(i));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        check("busy_mid_clear", {31'h0, busy}, 32'h1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        count_busy(n);
        check("reclear_cycles", n, 32'd256);
        model_clear();
        for (int i = 0; i < 8; i++) do_op("post4", 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
        load_const("post4_top", 2'b10, 1'b0, 32'h3FC, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_rw.md
Name: dmem_rw

Overview:
- Parametrised data memory for the single-cycle CPU.
- Generalises the plain word RAM in four ways:
  - configurable depth;
  - byte/half/word stores using byte-lane merge;
  - sign- or zero-extended sub-word loads;
  - a sequential clear engine that zeroes memory after reset, one word per cycle, with a busy flag.
- Sits between the ALU result/rs2 path and the writeback mux.
- Reads stay combinational, so single-cycle timing is kept.

Parameters:
- DEPTH, 256: number of 32-bit words; must be a power of 2, at least 4.
- ADDR_W, 32: width of the byte address input.
- IDX_W, $clog2(DEPTH): derived word-index width; do not override.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset, sampled on posedge clk
- we  in  1  store strobe, sampled on posedge clk
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- sign_ext  in  1  1 = sign-extend sub-word load, 0 = zero-extend
- addr  in  ADDR_W  byte address
- data_write  in  32  store data, low-aligned (byte in [7:0], half in [15:0])
- data_read  out  32  load data, combinational
- busy  out  1  clear engine active; memory not accessible
- err  out  1  access error, combinational (see Optional Feature)

Behaviour:
- Addressing:
  - Word index = addr[IDX_W+1:2].
  - Byte lane = addr[1:0]; half lane = addr[1].
- Reset:
  - reset_n low at a posedge sets state CLEAR, clr_ptr=0, busy=1.
  - While reset_n is held low, clr_ptr stays 0 and nothing is written.
  - err is never registered.
- CLEAR state:
  - Each posedge with reset_n high writes 0 to word clr_ptr, then increments clr_ptr.
  - The posedge that writes word DEPTH-1 moves the state to IDLE; busy reads 0 after that edge.
  - busy is therefore high for exactly DEPTH cycles after reset release.
  - During CLEAR: we is ignored and data_read = 0.
  - reset_n low mid-clear restarts from clr_ptr=0.
- IDLE state:
  - Stays in IDLE until reset. No other transitions.
- Load (combinational, IDLE only):
  - Fetch word W at the index, then select per size:
    - byte: W[8*lane+7 : 8*lane], extended per sign_ext.
    - half: W[16*addr[1]+15 : 16*addr[1]], extended per sign_ext.
    - word / size 11: W.
- Store (posedge, requires IDLE and we=1 and err=0):
  - byte: only lane addr[1:0] is written, with data_write[7:0].
  - half: only half addr[1] is written, with data_write[15:0].
  - word: the full word is written.
  - Untouched lanes keep their old value.
- Read-during-write, same address:
  - data_read shows the old contents until the edge and the new contents after it.
- No internal state beyond the array, the clear FSM and clr_ptr.

Optional Feature:
- Macro: DMEM_ERR_EN
- Defined:
  - err=1 when the access is misaligned: half with addr[0]=1, or word/size 11 with addr[1:0]!=0.
  - err=1 when the address is out of range: addr[ADDR_W-1:IDX_W+2] is non-zero.
  - When err=1, the store is suppressed and data_read=0.
  - err=0 while busy.
- Undefined:
  - err is tied to 0.
  - Half access ignores addr[0]; word access ignores addr[1:0].
  - Upper address bits are ignored, so addresses wrap modulo DEPTH*4.

Test Plan:
1. Clear timing: hold reset_n=0 for 3 cycles, then release, DEPTH=256 -> busy=1 for exactly 256 cycles, then 0. Load word @0x3FC -> 0x00000000. Store of 0xDEADBEEF @0x0 issued during busy -> 0x0 reads 0 after busy falls.
2. Byte store and sign-extended load: store word 0x11223344 @0x10, then store byte 0xAB @0x12 -> word @0x10 = 0x11AB3344. Byte load @0x12 with sign_ext=1 -> 0xFFFFFFAB; with sign_ext=0 -> 0x000000AB.
3. Half store: store half 0x8001 @0x22 into a zeroed word -> word @0x20 = 0x80010000. Half load sign_ext=1 -> 0xFFFF8001; sign_ext=0 -> 0x00008001.
4. Reset mid-clear: pull reset_n low at clear cycle 100 for 1 cycle -> busy stays high for a further 256 cycles after release. Words written before the abort read 0.
5. Read-during-write: word @0x40 = 0x5; issue store 0x7 @0x40 -> data_read = 0x5 before the edge and 0x7 after it.
6. With DMEM_ERR_EN: word store @0x42 -> err=1, memory unchanged. Store @0x400 with DEPTH=256 -> err=1. Without DMEM_ERR_EN: store @0x400 writes word 0, and @0x42 writes word @0x40.
